// File: rtl/in_fm_fifo_to_tile_buf_pkg.sv
// Shared accelerator definitions for the input feature-map loader: tile sizing,
// bank count and the loader FSM encoding.
package in_fm_fifo_to_tile_buf_pkg;

    localparam int unsigned TM_DEF    = 8;
    localparam int unsigned TR_DEF    = 16;
    localparam int unsigned TC_DEF    = 8;
    localparam int unsigned TILE      = TM_DEF * TR_DEF * TC_DEF;
    localparam int unsigned NUM_BANKS = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BANK,
        LOAD,
        FLUSH,
        DONE
    } state_t;

    function automatic int unsigned tile_words(input int unsigned tm, input int unsigned tr,
                                               input int unsigned tc);
        return tm * tr * tc;
    endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-latency register chain: q is d delayed by D clocks, cleared on reset.
module sig_delay #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [D-1:0][W-1:0] vld_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= d;
            for (int i = 1; i < D; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign q = vld_pipe[D-1];

endmodule

// File: rtl/in_fm_fifo_to_tile_buf.sv
// Streams one tile of input feature-map words from the FIFO into a ping-pong
// tile buffer, tracking which bank holds a complete tile for the compute stage.
module in_fm_fifo_to_tile_buf
    import in_fm_fifo_to_tile_buf_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 12,
    parameter int Tm = TM_DEF,
    parameter int Tr = TR_DEF,
    parameter int Tc = TC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 done,
    input  logic                 conv_tile_clean,
    output logic                 fifo_pop,
    input  logic                 fifo_empty,
    input  logic [DW-1:0]        data_from_fifo,
    output logic                 buf_wr_ena,
    output logic [AW-1:0]        buf_wr_addr,
    output logic [DW-1:0]        buf_wr_data,
    output logic [NUM_BANKS-1:0] bank_ready
);

    localparam int unsigned TILE_N = tile_words(Tm, Tr, Tc);
    localparam int          CW     = $clog2(TILE_N) + 1;

    state_t                 state, state_nxt;
    logic [CW-1:0]          pop_cnt, wr_cnt;
    logic                   wr_bank, rd_bank;
    logic [NUM_BANKS-1:0]   bank_ready_nxt;
    logic                   last_wr, clean_ok;

    assign fifo_pop = (state == LOAD) && !fifo_empty && (pop_cnt < CW'(TILE_N));
    assign done     = (state == DONE);
    assign last_wr  = buf_wr_ena && (wr_cnt == CW'(TILE_N - 1));
    assign clean_ok = conv_tile_clean && bank_ready[rd_bank];

    // Write side trails the pop by exactly one cycle, matching FIFO read latency.
    sig_delay #(.W(1), .D(1)) u_wr_dly (
        .clk (clk),
        .rst (rst),
        .d   (fifo_pop),
        .q   (buf_wr_ena)
    );

    assign buf_wr_addr = AW'(wr_bank) * AW'(TILE_N) + AW'(wr_cnt);
    assign buf_wr_data = buf_wr_ena ? data_from_fifo : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = WAIT_BANK;
            WAIT_BANK: if (!bank_ready[wr_bank]) state_nxt = LOAD;
            LOAD:      if (fifo_pop && pop_cnt == CW'(TILE_N - 1)) state_nxt = FLUSH;
            // The last write lands in the first FLUSH cycle; leave as it commits.
            FLUSH:     if (last_wr || wr_cnt == CW'(TILE_N)) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bank_ready_nxt = bank_ready;
        if (state == DONE) bank_ready_nxt[wr_bank] = 1'b1;
        if (clean_ok)      bank_ready_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pop_cnt    <= '0;
            wr_cnt     <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            bank_ready <= '0;
        end else begin
            state      <= state_nxt;
            bank_ready <= bank_ready_nxt;
            if (state == IDLE && start) begin
                pop_cnt <= '0;
                wr_cnt  <= '0;
            end else begin
                if (fifo_pop)   pop_cnt <= pop_cnt + 1'b1;
                if (buf_wr_ena) wr_cnt  <= wr_cnt + 1'b1;
            end
            if (state == DONE) wr_bank <= ~wr_bank;
            if (clean_ok)      rd_bank <= ~rd_bank;
        end
    end

endmodule

// File: tb/tb_in_fm_fifo_to_tile_buf.sv
// Directed bench for the tile loader: table of tile runs plus hand sequences for
// back-pressure, coincident clean/done, ignored start and reset mid-load.
module tb_in_fm_fifo_to_tile_buf;
    import in_fm_fifo_to_tile_buf_pkg::*;

    localparam int DW = 32;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst, start, conv_tile_clean, fifo_empty, fifo_pop, done, buf_wr_ena;
    logic [DW-1:0] data_from_fifo, buf_wr_data;
    logic [AW-1:0] buf_wr_addr;
    logic [1:0]    bank_ready;

    in_fm_fifo_to_tile_buf #(.DW(DW), .AW(AW), .Tm(8), .Tr(16), .Tc(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .done            (done),
        .conv_tile_clean (conv_tile_clean),
        .fifo_pop        (fifo_pop),
        .fifo_empty      (fifo_empty),
        .data_from_fifo  (data_from_fifo),
        .buf_wr_ena      (buf_wr_ena),
        .buf_wr_addr     (buf_wr_addr),
        .buf_wr_data     (buf_wr_data),
        .bank_ready      (bank_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: read data appears the cycle after a pop; optional forced-empty gap.
    logic [DW-1:0] fmem [0:8191];
    int wptr = 0, rptr = 0, rptr_off = 0, pops = 0, pops_base = 0;
    int stall_at = 0, stall_len = 0, stall_rem = 0;
    assign fifo_empty = ((rptr + rptr_off) >= wptr) || (stall_rem > 0);

    always @(posedge clk) begin
        if (fifo_pop) begin
            data_from_fifo <= fmem[(rptr + rptr_off) % 8192];
            rptr           <= rptr + 1;
            pops           <= pops + 1;
        end
        if (stall_rem > 0)
            stall_rem <= stall_rem - 1;
        else if (fifo_pop && stall_len > 0 && (pops + 1 - pops_base) == stall_at)
            stall_rem <= stall_len;
    end

    // Write/strobe monitor, sampled on the falling edge.
    logic [AW-1:0] log_addr [0:4095];
    logic [DW-1:0] log_data [0:4095];
    int n_wr = 0, bad_pop = 0, pop_seen = 0, n_done = 0;
    always @(negedge clk) begin
        if (buf_wr_ena) begin
            log_addr[n_wr % 4096] = buf_wr_addr;
            log_data[n_wr % 4096] = buf_wr_data;
            n_wr++;
        end
        if (fifo_pop && fifo_empty) bad_pop++;
        if (fifo_pop) pop_seen++;
        if (done) n_done++;
    end

    int n_cmp = 0, n_bad = 0;
    int cyc_start = 0, wr_base = 0, bp_base = 0, ps_base = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_fifo_pop"}, int'(fifo_pop), 0);
        check({tag, "_wr_ena"}, int'(buf_wr_ena), 0);
        check({tag, "_wr_addr"}, int'(buf_wr_addr), 0);
        check({tag, "_wr_data"}, int'(buf_wr_data), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_bank_ready"}, int'(bank_ready), 0);
    endtask

    task automatic push_tile(input int tag);
        for (int k = 0; k < int'(TILE); k++) begin
            fmem[wptr % 8192] = DW'((tag << 16) | k);
            wptr++;
        end
    endtask

    task automatic arm(input int s_at, input int s_len);
        wr_base   = n_wr;
        bp_base   = bad_pop;
        ps_base   = pop_seen;
        pops_base = pops;
        stall_at  = s_at;
        stall_len = s_len;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        cyc_start = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_clean();
        @(negedge clk);
        conv_tile_clean = 1'b1;
        @(negedge clk);
        conv_tile_clean = 1'b0;
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = -1;
        for (int t = 0; t < 4000; t++) begin
            if (done) begin
                lat = cyc - cyc_start;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) check({name, "_done_timeout"}, 0, 1);
    endtask

    task automatic check_seq(input string name, input int tag, input int base);
        int bad = -1;
        check({name, "_wr_count"}, n_wr - wr_base, int'(TILE));
        for (int k = 0; k < int'(TILE) && k < n_wr - wr_base; k++) begin
            if (bad < 0 && (log_addr[(wr_base + k) % 4096] != AW'(base + k) ||
                            log_data[(wr_base + k) % 4096] != DW'((tag << 16) | k)))
                bad = k;
        end
        check({name, "_wr_seq_first_bad"}, bad, -1);
        check({name, "_pop_while_empty"}, bad_pop - bp_base, 0);
    endtask

    typedef struct {
        int         tag;
        bit         clean_before;
        int         stall_at;
        int         stall_len;
        int         exp_lat;
        logic [1:0] exp_ready;
        int         exp_base;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int lat;
        int done_snap;
        vecs[0] = '{0, 1'b0, 0,   0,  1027, 2'b01, 0};
        vecs[1] = '{1, 1'b0, 100, 10, 1037, 2'b11, 1024};
        vecs[2] = '{2, 1'b1, 0,   0,  1027, 2'b11, 0};
        vecs[3] = '{3, 1'b1, 512, 3,  1030, 2'b11, 1024};

        rst = 1'b1; start = 1'b0; conv_tile_clean = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].clean_before) pulse_clean();
            push_tile(vecs[i].tag);
            arm(vecs[i].stall_at, vecs[i].stall_len);
            pulse_start();
            wait_done($sformatf("row%0d", i), lat);
            check($sformatf("row%0d_latency", i), lat, vecs[i].exp_lat);
            @(negedge clk);
            check($sformatf("row%0d_done_width", i), int'(done), 0);
            check($sformatf("row%0d_bank_ready", i), int'(bank_ready), int'(vecs[i].exp_ready));
            check_seq($sformatf("row%0d", i), vecs[i].tag, vecs[i].exp_base);
        end

        // Both banks full: the next tile must hold off until a bank is released.
        push_tile(5);
        arm(0, 0);
        pulse_start();
        repeat (20) @(negedge clk);
        check("bp_no_pop", pop_seen - ps_base, 0);
        check("bp_no_write", n_wr - wr_base, 0);
        check("bp_ready_held", int'(bank_ready), 2'b11);
        pulse_clean();
        check("bp_ready_after_clean", int'(bank_ready), 2'b10);
        wait_done("bp", lat);
        @(negedge clk);
        check("bp_bank_ready", int'(bank_ready), 2'b11);
        check_seq("bp", 5, 0);

        // Release bank 1, then land a clean on the DONE cycle of the next tile.
        pulse_clean();
        check("sim_pre_ready", int'(bank_ready), 2'b01);
        push_tile(6);
        arm(0, 0);
        pulse_start();
        wait_done("sim", lat);
        conv_tile_clean = 1'b1;
        @(negedge clk);
        conv_tile_clean = 1'b0;
        check("sim_bank_ready", int'(bank_ready), 2'b10);
        check_seq("sim", 6, 1024);
        pulse_clean();
        check("sim_rd_bank_one", int'(bank_ready), 2'b00);

        // A second start during LOAD must not queue another tile.
        push_tile(7);
        push_tile(8);
        arm(0, 0);
        done_snap = n_done;
        pulse_start();
        repeat (200) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", lat);
        check("ign_latency", lat, 1027);
        check_seq("ign", 7, 0);
        repeat (1200) @(negedge clk);
        check("ign_done_count", n_done - done_snap, 1);
        check("ign_bank_ready", int'(bank_ready), 2'b01);

        // Reset in the middle of a load; the bank is left unclaimed.
        rptr_off = wptr - rptr;
        push_tile(9);
        arm(0, 0);
        pulse_start();
        for (int t = 0; t < 2000 && (n_wr - wr_base) < 500; t++) @(negedge clk);
        check("rst_reached_500", int'((n_wr - wr_base) >= 500), 1);
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        rptr_off = wptr - rptr;
        push_tile(10);
        arm(0, 0);
        pulse_start();
        wait_done("post_rst", lat);
        check("post_rst_latency", lat, 1027);
        @(negedge clk);
        check("post_rst_bank_ready", int'(bank_ready), 2'b01);
        check_seq("post_rst", 10, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
